// File: rtl/gpu_pkg.sv
// gpu_pkg: shared triangle descriptor layout, frame constants and scheduler states.
package gpu_pkg;
  localparam int FB_W = 320;
  localparam int FB_H = 240;
  localparam logic [7:0] Z_FAR = 8'hFF;
  typedef struct packed {
    logic [31:0] inv_area;
    logic [7:0]  color;
    logic [9:0]  a1;
    logic [9:0]  b1;
    logic [9:0]  a2;
    logic [9:0]  b2;
    logic [9:0]  a3;
    logic [9:0]  b3;
    logic [17:0] c1;
    logic [17:0] c2;
    logic [17:0] c3;
    logic [8:0]  bbxi;
    logic [8:0]  bbxf;
    logic [7:0]  bbyi;
    logic [7:0]  bbyf;
    logic [15:0] z1;
    logic [15:0] z2;
    logic [15:0] z3;
  } tri_desc_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_CLEAR} state_t;
endpackage

// File: rtl/desc_fifo.sv
// desc_fifo: first-word-fall-through synchronous FIFO; the caller guarantees
// push only when not full and pop only when not empty.
module desc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [LW-1:0] r_level;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (push) r_wp <= r_wp + AW'(1);
      if (pop) r_rp <= r_rp + AW'(1);
      r_level <= r_level + LW'(push) - LW'(pop);
    end
  always_ff @(posedge clk)
    if (push) r_mem[r_wp] <= din;
  assign dout  = r_mem[r_rp];
  assign level = r_level;
endmodule

// File: rtl/raster_scheduler.sv
// raster_scheduler: queues triangle descriptors, launches the rasterizer one at a time,
// and arbitrates the frame/Z-buffer ports between the rasterizer and the frame-clear engine.
module raster_scheduler
  import gpu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int FB_PIXELS = FB_W * FB_H
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tri_valid,
  input  tri_desc_t              tri_data,
  output logic                   tri_ready,
  input  logic                   clear_req,
  input  logic [7:0]             clear_color,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output tri_desc_t              rast_desc,
  output logic                   rasterizer_start,
  input  logic                   rasterizer_done,
  input  logic                   r_fb_we,
  input  logic [7:0]             r_fb_din,
  input  logic [16:0]            r_fb_addr,
  input  logic                   r_zb_we,
  input  logic [7:0]             r_zb_din,
  input  logic [16:0]            r_zb_addr,
  output logic [7:0]             r_zb_dout,
  output logic                   fb_we,
  output logic [7:0]             fb_din,
  output logic [16:0]            fb_addr,
  output logic                   zb_we,
  output logic [7:0]             zb_din,
  output logic [16:0]            zb_addr,
  output logic                   zb_en,
  input  logic [7:0]             zb_dout
);
  localparam int LW = $clog2(DEPTH) + 1;
  state_t    r_state;
  state_t    w_next;
  tri_desc_t r_desc;
  tri_desc_t w_head;
  logic      r_clr_pending;
  logic [7:0]  r_clr_color;
  logic [16:0] r_addr;
  logic w_push;
  logic w_wait;
  logic w_clr;
  logic w_last;
  assign tri_ready = (level != LW'(DEPTH));
  assign w_push    = tri_valid & tri_ready;
  assign w_wait    = (r_state == S_WAIT);
  assign w_clr     = (r_state == S_CLEAR);
  assign w_last    = (r_addr == 17'(FB_PIXELS - 1));
  desc_fifo #(.W($bits(tri_desc_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(w_push), .pop(r_state == S_LOAD),
    .din(tri_data), .dout(w_head), .level(level)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state       <= S_IDLE;
      r_desc        <= '0;
      r_clr_pending <= 1'b0;
      r_clr_color   <= '0;
      r_addr        <= '0;
    end else begin
      r_state       <= w_next;
      r_clr_pending <= clear_req | (r_clr_pending & ~(w_clr & w_last));
      r_addr        <= w_clr ? r_addr + 17'd1 : '0;
      if (clear_req) r_clr_color <= clear_color;
      if (r_state == S_LOAD) r_desc <= w_head;
    end
  // Clear wins over queued triangles, but only ever from IDLE, so a running triangle finishes first.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = r_clr_pending ? S_CLEAR : (level != '0 ? S_LOAD : S_IDLE);
      S_LOAD:  w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  w_next = rasterizer_done ? S_IDLE : S_WAIT;
      S_CLEAR: w_next = w_last ? S_IDLE : S_CLEAR;
      default: w_next = S_IDLE;
    endcase
  end
  assign rast_desc        = r_desc;
  assign rasterizer_start = (r_state == S_START);
  assign busy             = (r_state != S_IDLE) | (level != '0) | r_clr_pending;
  assign fb_we     = w_wait ? r_fb_we : w_clr;
  assign fb_din    = w_wait ? r_fb_din : (w_clr ? r_clr_color : 8'h00);
  assign fb_addr   = w_wait ? r_fb_addr : (w_clr ? r_addr : 17'd0);
  assign zb_we     = w_wait ? r_zb_we : w_clr;
  assign zb_din    = w_wait ? r_zb_din : (w_clr ? Z_FAR : 8'h00);
  assign zb_addr   = w_wait ? r_zb_addr : (w_clr ? r_addr : 17'd0);
  assign zb_en     = w_wait | w_clr;
  assign r_zb_dout = zb_dout;
endmodule

// File: tb/tb_raster_scheduler.sv
// tb_raster_scheduler: random descriptors and clears against a queue-based scoreboard,
// with a behavioural rasterizer that answers each launch after a chosen run length.
module tb_raster_scheduler;
  import gpu_pkg::*;
  localparam int DEPTH = 4;
  localparam int FBP   = 1200;
  logic clk = 0;
  logic rst = 1;
  logic tri_valid = 0;
  tri_desc_t tri_data = '0;
  logic tri_ready;
  logic clear_req = 0;
  logic [7:0] clear_color = 0;
  logic busy;
  logic [$clog2(DEPTH):0] level;
  tri_desc_t rast_desc;
  logic rasterizer_start;
  logic m_done = 0;
  logic x_done = 0;
  logic rasterizer_done;
  logic r_fb_we = 0;
  logic [7:0] r_fb_din = 0;
  logic [16:0] r_fb_addr = 0;
  logic r_zb_we = 0;
  logic [7:0] r_zb_din = 0;
  logic [16:0] r_zb_addr = 0;
  logic [7:0] r_zb_dout;
  logic fb_we, zb_we, zb_en;
  logic [7:0] fb_din, zb_din;
  logic [16:0] fb_addr, zb_addr;
  logic [7:0] zb_dout = 0;
  int n_tests = 0, n_fail = 0, cyc = 0;
  tri_desc_t exp_q[$];
  int starts[$];
  int dones[$];
  int clr_cnt = 0, clr_bad = 0, clr_bad_tot = 0, clr_first = 0, clr_last = 0;
  logic prev_clr = 0;
  logic [7:0] exp_clr_color = 0;
  logic rast_wr = 0;
  int rast_len = 10;
  int last_push = 0;
  logic saw_full = 0;
  assign rasterizer_done = m_done | x_done;

  raster_scheduler #(.DEPTH(DEPTH), .FB_PIXELS(FBP)) dut (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_data(tri_data), .tri_ready(tri_ready),
    .clear_req(clear_req), .clear_color(clear_color), .busy(busy), .level(level),
    .rast_desc(rast_desc), .rasterizer_start(rasterizer_start), .rasterizer_done(rasterizer_done),
    .r_fb_we(r_fb_we), .r_fb_din(r_fb_din), .r_fb_addr(r_fb_addr),
    .r_zb_we(r_zb_we), .r_zb_din(r_zb_din), .r_zb_addr(r_zb_addr), .r_zb_dout(r_zb_dout),
    .fb_we(fb_we), .fb_din(fb_din), .fb_addr(fb_addr),
    .zb_we(zb_we), .zb_din(zb_din), .zb_addr(zb_addr), .zb_en(zb_en), .zb_dout(zb_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic tri_desc_t rnd_desc();
    logic [255:0] v;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return v[235:0];
  endfunction

  task automatic push(input tri_desc_t d);
    int t = 0;
    tri_valid = 1;
    tri_data  = d;
    while (!tri_ready && t < 2000) begin
      if (level == 3'(DEPTH)) saw_full = 1;
      @(negedge clk);
      t++;
    end
    chk("push_accept", tri_ready, 1);
    exp_q.push_back(d);
    @(negedge clk);
    last_push = cyc;
    tri_valid = 0;
  endtask

  task automatic wait_starts(input int n, input int lim);
    int t = 0;
    while (starts.size() < n && t < lim) begin @(negedge clk); t++; end
    chk("wait_start", starts.size() >= n, 1);
  endtask

  task automatic wait_dones(input int n, input int lim);
    int t = 0;
    while (dones.size() < n && t < lim) begin @(negedge clk); t++; end
    chk("wait_done", dones.size() >= n, 1);
  endtask

  task automatic req_clear(input logic [7:0] c);
    exp_clr_color = c;
    clear_color   = c;
    clear_req     = 1;
    @(negedge clk);
    clear_req = 0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_level"}, level, 0);
    chk({nm, "_ready"}, tri_ready, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_desc"}, rast_desc, 0);
    chk({nm, "_start"}, rasterizer_start, 0);
    chk({nm, "_fb_we"}, fb_we, 0);
    chk({nm, "_zb_we"}, zb_we, 0);
    chk({nm, "_zb_en"}, zb_en, 0);
  endtask

  // Scoreboard monitor: every launch must carry the oldest accepted descriptor;
  // every clear write must walk addresses 0.. in order with the requested colour and far-Z.
  initial begin : mon
    tri_desc_t e;
    forever begin
      @(negedge clk);
      if (rasterizer_start) begin
        starts.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("start_desc", rast_desc, e);
        end
      end
      if (fb_we && !rast_wr) begin
        if (!prev_clr) begin clr_cnt = 0; clr_bad = 0; clr_first = cyc; end
        if (fb_addr != 17'(clr_cnt) || fb_din != exp_clr_color || !zb_we || zb_din != 8'hFF ||
            zb_addr != 17'(clr_cnt) || !zb_en) begin
          clr_bad++;
          clr_bad_tot++;
        end
        clr_cnt++;
        clr_last = cyc;
      end
      prev_clr = fb_we && !rast_wr;
    end
  end

  // Rasterizer model: runs rast_len cycles per launch, then pulses done once.
  initial begin : rast
    tri_desc_t held;
    int n;
    logic bad;
    forever begin
      @(negedge clk);
      if (rasterizer_start) begin
        held = rast_desc;
        n    = rast_len;
        bad  = 0;
        repeat (n) begin
          @(negedge clk);
          if (rast_desc !== held) bad = 1;
        end
        m_done = 1;
        @(negedge clk);
        m_done = 0;
        dones.push_back(cyc);
        chk("desc_hold", bad, 0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tri_desc_t d;
    int ns, nd, r, b, t;
    repeat (3) @(negedge clk);
    chk_reset_outputs("in_reset");
    rst = 0;
    @(negedge clk);
    chk_reset_outputs("after_reset");
    zb_dout = 8'hA5;
    #1 chk("zb_dout_pass", r_zb_dout, 8'hA5);

    // Single launch: latency, colour and port pass-through during WAIT.
    rast_len = 20;
    ns = starts.size();
    nd = dones.size();
    d = rnd_desc();
    d.color = 8'h3C;
    push(d);
    wait_starts(ns + 1, 50);
    chk("t1_latency", starts[ns] - last_push, 2);
    @(negedge clk);
    chk("t1_color", rast_desc.color, 8'h3C);
    rast_wr = 1;
    r_fb_we = 1; r_fb_din = 8'($urandom); r_fb_addr = 17'($urandom);
    r_zb_we = 1; r_zb_din = 8'($urandom); r_zb_addr = 17'($urandom);
    zb_dout = 8'($urandom);
    #1;
    chk("t1_fb_we", fb_we, 1);
    chk("t1_fb_din", fb_din, r_fb_din);
    chk("t1_fb_addr", fb_addr, r_fb_addr);
    chk("t1_zb_we", zb_we, 1);
    chk("t1_zb_din", zb_din, r_zb_din);
    chk("t1_zb_addr", zb_addr, r_zb_addr);
    chk("t1_zb_en", zb_en, 1);
    chk("t1_zb_dout", r_zb_dout, zb_dout);
    @(negedge clk);
    r_fb_we = 0; r_zb_we = 0; rast_wr = 0;
    wait_dones(nd + 1, 100);
    repeat (5) @(negedge clk);
    chk("t1_single_start", starts.size(), ns + 1);

    // Back-to-back: fill the FIFO and check the 3-cycle turnaround.
    rast_len = 50;
    ns = starts.size();
    nd = dones.size();
    saw_full = 0;
    for (int i = 0; i < 6; i++) push(rnd_desc());
    chk("t2_full", saw_full, 1);
    wait_dones(nd + 6, 2000);
    for (int i = 1; i < 6; i++) chk("t2_gap", starts[ns + i] - dones[nd + i - 1], 2);

    // Idle clear: full sweep, then busy falls.
    @(negedge clk);
    req_clear(8'h12);
    r = cyc;
    b = 0;
    while (busy && b < FBP + 100) begin b++; @(negedge clk); end
    chk("t3_busy_cycles", b, FBP + 1);
    chk("t3_first", clr_first, r + 1);
    chk("t3_count", clr_cnt, FBP);
    chk("t3_writes", clr_bad, 0);

    // Clear requested mid-triangle with two queued behind it.
    rast_len = 60;
    ns = starts.size();
    nd = dones.size();
    for (int i = 0; i < 3; i++) push(rnd_desc());
    wait_starts(ns + 1, 50);
    req_clear(8'($urandom));
    wait_dones(nd + 3, FBP + 2000);
    chk("t4_clear_after_done", clr_first, dones[nd] + 1);
    chk("t4_start_after_clear", starts[ns + 1], clr_last + 3);
    chk("t4_count", clr_cnt, FBP);
    chk("t4_writes", clr_bad, 0);

    // Rasterizer activity outside WAIT is blocked; stray done is ignored.
    @(negedge clk);
    ns = starts.size();
    r_fb_we = 1; r_zb_we = 1; r_fb_addr = 17'd77; r_zb_addr = 17'd88;
    #1;
    chk("t5_fb_we", fb_we, 0);
    chk("t5_zb_we", zb_we, 0);
    chk("t5_zb_en", zb_en, 0);
    @(negedge clk);
    r_fb_we = 0; r_zb_we = 0;
    x_done = 1;
    @(negedge clk);
    x_done = 0;
    repeat (5) @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_no_start", starts.size(), ns);

    // Reset mid-clear with descriptors queued.
    req_clear(8'($urandom));
    for (int i = 0; i < 3; i++) push(rnd_desc());
    chk("t6_level", level, 3);
    t = 0;
    while (!(fb_we && fb_addr == 17'd1000) && t < 3 * FBP) begin @(negedge clk); t++; end
    chk("t6_reach_1000", fb_addr, 1000);
    ns = starts.size();
    rst = 1;
    #1 chk_reset_outputs("t6_rst");
    exp_q.delete();
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("t6_no_start", starts.size(), ns);
    chk("t6_busy", busy, 0);

    // Random traffic with occasional clears.
    nd = dones.size();
    for (int i = 0; i < 10; i++) begin
      rast_len = $urandom_range(3, 30);
      if ($urandom_range(0, 3) == 0 && !fb_we) req_clear(8'($urandom));
      push(rnd_desc());
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    wait_dones(nd + 10, 20000);
    t = 0;
    while (busy && t < 3 * FBP) begin @(negedge clk); t++; end
    chk("t7_idle", busy, 0);
    chk("t7_queue_empty", exp_q.size(), 0);
    chk("all_clear_writes", clr_bad_tot, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
